// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the time-shared adder controller.
package adder_share_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a requester count, never narrower than one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/carry_bypass_adder.sv
// Combinational carry-bypass adder built from BLK_W-bit ripple blocks.
module carry_bypass_adder #(
  parameter int DATA_W = 32,
  parameter int BLK_W  = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic c;
  logic cb;
  logic bp;

  always_comb begin
    sum  = '0;
    c    = cin;
    cb   = 1'b0;
    bp   = 1'b0;
    for (int blk = 0; blk < DATA_W / BLK_W; blk++) begin
      cb = c;
      bp = 1'b1;
      for (int k = 0; k < BLK_W; k++) begin
        sum[blk*BLK_W+k] = a[blk*BLK_W+k] ^ b[blk*BLK_W+k] ^ c;
        c  = (a[blk*BLK_W+k] & b[blk*BLK_W+k]) | ((a[blk*BLK_W+k] ^ b[blk*BLK_W+k]) & c);
        bp = bp & (a[blk*BLK_W+k] ^ b[blk*BLK_W+k]);
      end
      // A fully propagating block forwards its incoming carry directly
      if (bp) c = cb;
    end
    cout = c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts just above last_grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one carry-bypass adder among N_REQ requesters: grant, execute, respond.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ-1:0]          req_cin,
  input  logic [N_REQ-1:0]          req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic signed [DATA_W-1:0]  rsp_sum,
  output logic                      rsp_cout,
  output logic                      rsp_ovf
);

  function automatic logic ovf_fn(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t                   state, next_state;
  logic [ID_W-1:0]          last_grant;
  logic [N_REQ-1:0]         gnt;
  logic [ID_W-1:0]          gnt_idx;
  logic [DATA_W-1:0]        sel_a, sel_b;
  logic                     sel_sub, sel_cin;
  logic signed [DATA_W-1:0] op_a_p0, op_b_p0;
  logic                     op_cin_p0;
  logic [ID_W-1:0]          op_id_p0;
  logic [DATA_W-1:0]        sum_p1;
  logic                     cout_p1;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         ((state == IDLE) && rst_n),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign req_ready = gnt;
  assign sel_a     = req_a[gnt_idx*DATA_W +: DATA_W];
  assign sel_b     = req_b[gnt_idx*DATA_W +: DATA_W];
  assign sel_sub   = req_sub[gnt_idx];
  assign sel_cin   = req_cin[gnt_idx];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|gnt) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: operand latch in the grant cycle; subtraction folded into ~B + 1
  always_ff @(posedge clk) begin
    if (state == IDLE && |gnt) begin
      op_a_p0   <= sel_a;
      op_b_p0   <= sel_sub ? ~sel_b : sel_b;
      op_cin_p0 <= sel_sub | sel_cin;
      op_id_p0  <= gnt_idx;
    end
  end

  carry_bypass_adder #(.DATA_W(DATA_W), .BLK_W(4)) u_add (
    .a    (op_a_p0),
    .b    (op_b_p0),
    .cin  (op_cin_p0),
    .sum  (sum_p1),
    .cout (cout_p1)
  );

  // Stage p1: adder result registered onto the response port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && |gnt) last_grant <= gnt_idx;
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id_p0;
        rsp_sum   <= sum_p1;
        rsp_cout  <= cout_p1;
        rsp_ovf   <= ovf_fn(op_a_p0[DATA_W-1], op_b_p0[DATA_W-1], sum_p1[DATA_W-1]);
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl with directed arithmetic, arbitration and reset cases.
module tb_adder_share_ctrl;

  localparam int N = 4;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic [N-1:0]    req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_sum;
  logic            rsp_cout;
  logic            rsp_ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   gnt_log[$];

  adder_share_ctrl #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int i);
    exp_t        e;
    logic [31:0] a, b, bb;
    logic [32:0] s;
    a  = req_a[i*32 +: 32];
    b  = req_b[i*32 +: 32];
    bb = req_sub[i] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'b0, (req_sub[i] | req_cin[i])};
    e.id   = i[1:0];
    e.sum  = s[31:0];
    e.cout = s[32];
    e.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
    return e;
  endfunction

  // Monitor: push on accept, pop and compare on response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(i));
          gnt_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id",   64'(rsp_id),   64'(e.id));
          chk("sb_sum",  64'(rsp_sum),  64'(e.sum));
          chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
          chk("sb_ovf",  64'(rsp_ovf),  64'(e.ovf));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = cin;
    req_sub[i]        = sub;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo, input string tag);
    bit hit;
    int t_acc;
    @(posedge clk); #1;
    set_req(i, a, b, cin, sub);
    req_valid[i] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        hit = 1'b1;
        break;
      end
    end
    chk({tag, "_accept"}, 64'(hit), 64'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        hit = 1'b1;
        break;
      end
    end
    chk({tag, "_rspvalid"}, 64'(hit), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - t_acc), 64'd2);
    chk({tag, "_sum"},  64'(rsp_sum),  64'(es));
    chk({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
    chk({tag, "_ovf"},  64'(rsp_ovf),  64'(eo));
    chk({tag, "_id"},   64'(rsp_id),   64'(i));
    drain();
  endtask

  initial begin
    int          exp_ord[5];
    bit          hit;
    logic [31:0] s_sum;
    logic [1:0]  s_id;
    logic        s_cout, s_ovf;

    exp_ord   = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(i + 2), 1'b0, 1'b0);
    req_valid = '1;

    // Reset held with every requester valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  64'(req_ready), 64'd0);
    chk("rst_valid",  64'(rsp_valid), 64'd0);
    chk("rst_id",     64'(rsp_id),    64'd0);
    chk("rst_sum",    64'(rsp_sum),   64'd0);
    chk("rst_cout",   64'(rsp_cout),  64'd0);
    chk("rst_ovf",    64'(rsp_ovf),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Directed arithmetic cases
    run_one(0, 32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0, "add");
    run_one(2, 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub");
    run_one(1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "posovf");
    run_one(3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "wrap");
    run_one(3, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "negovf");

    // Round-robin with all requesters continuously valid
    gnt_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h1000 * (i + 1), 32'(i + 10), i[0], (i == 2));
    req_valid = '1;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (gnt_log.size() >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", 64'(hit), 64'd1);
    if (hit) for (int k = 0; k < 5; k++) chk("rr_order", 64'(gnt_log[k]), 64'(exp_ord[k]));
    drain();

    // Backpressure: response held while rsp_ready stays low
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1, 32'd100, 32'd23, 1'b0, 1'b0);
    set_req(2, 32'd40, 32'd2, 1'b1, 1'b0);
    req_valid[1] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        hit = 1'b1;
        break;
      end
    end
    chk("bp_accept", 64'(hit), 64'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        hit = 1'b1;
        break;
      end
    end
    chk("bp_rspvalid", 64'(hit), 64'd1);
    s_sum = rsp_sum; s_id = rsp_id; s_cout = rsp_cout; s_ovf = rsp_ovf;
    chk("bp_sum", 64'(s_sum), 64'd123);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_ready", 64'(req_ready), 64'd0);
      chk("bp_hold_data",  64'({rsp_sum, rsp_id, rsp_cout, rsp_ovf}),
                           64'({s_sum, s_id, s_cout, s_ovf}));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset while in EXEC: nothing emitted, pointer restarts at requester 0
    @(posedge clk); #1;
    set_req(0, 32'd9, 32'd9, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_accept", 64'(hit), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(3, 32'd1, 32'd1, 1'b0, 1'b0);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
